ps2_keyboard_rx: RTL and testbench
==================================

# ps2_keyboard_rx

Receives PS/2 keyboard frames on the board's `ps2_clk`/`ps2_data` pins, validates them, and queues the scan-code bytes in a small FIFO. It sits directly upstream of the board top: the top pops bytes through a valid/ready handshake and drives `seg*`/`ledr` from them. Everything runs in the system clock domain; the PS/2 lines are treated as asynchronous inputs.

## Interface
- `FIFO_DEPTH`, 8: number of byte entries; must be a power of 2, ≥2.
- `TIMEOUT_CYCLES`, 100000: `clk` cycles without a PS/2 falling edge before a partial frame is abandoned.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `ps2_clk`  in  1  raw PS/2 clock from the pin, asynchronous.
- `ps2_data`  in  1  raw PS/2 data from the pin, asynchronous.
- `ready`  in  1  consumer accepts the head byte this cycle.
- `valid`  out  1  FIFO is non-empty; `data` holds the head byte.
- `data`  out  8  head-of-FIFO scan code (show-ahead).
- `overflow`  out  1  sticky; a good byte was dropped because the FIFO was full.
- `parity_err`  out  1  one-cycle pulse; a frame was dropped for bad odd parity.
- `frame_err`  out  1  one-cycle pulse; bad start bit, bad stop bit, or timeout.

## Operation
- Synchronizers: `ps2_clk` through 3 flops (s0→s1→s2); `ps2_data` through 2 flops. `fall` = s2 & ~s1, asserted for one cycle per falling edge. Data is sampled from the 2nd data flop in the `fall` cycle.
- Frame format, LSB first: start bit (0), d[0..7], odd parity bit, stop bit (1). 11 falling edges per frame.
- State machine:
  - IDLE, on `fall`: if the sample is 0, go to DATA with bit count = 0. If the sample is 1, pulse `frame_err` and stay in IDLE.
  - DATA: on each `fall`, shift the sample into bit[count]. After the 8th bit, go to PARITY.
  - PARITY: on `fall`, capture the parity bit and go to STOP.
  - STOP: on `fall`, return to IDLE.
    - Stop = 0: pulse `frame_err` and drop the byte. This takes precedence; `parity_err` is not raised.
    - Else if ^{d,parity} == 0: pulse `parity_err` and drop the byte.
    - Else: push the byte.
- Timeout: in any state other than IDLE, a counter is cleared on each `fall` and increments otherwise. When it reaches TIMEOUT_CYCLES: pulse `frame_err`, go to IDLE, discard the partial byte. The counter is held at 0 in IDLE.
- FIFO:
  - `pop` = `valid` & `ready`.
  - A push is accepted if the FIFO is not full, or if `pop` occurs in the same cycle.
  - A push while full without `pop` drops the byte and sets `overflow`. The FIFO contents are unchanged.
  - Push and pop in the same cycle leave the count unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH. Full/empty are tracked with an extra pointer bit.
  - There is no bypass: a byte pushed into an empty FIFO is visible the next cycle.
- `ready` while `valid`=0 has no effect.

## Timing
- Reset values: `valid`=0, `data`=8'h00, `overflow`=0, `parity_err`=0, `frame_err`=0. State = IDLE, pointers = 0, synchronizer flops = 1 (line idle level).
- `rst` mid-frame discards the partial frame and all FIFO contents. `overflow` clears only on `rst`.
- Latency:
  - Pin edge to `fall`: 3 cycles.
  - The push happens on the clock edge that ends the `fall` cycle of the stop bit. `valid` rises in the next cycle.
- `parity_err` and `frame_err` are registered and high for exactly the cycle after the decision.
- `data` changes only on a pop, or on a push into an empty FIFO.

## Structure
- Package `ps2_pkg`:
  - state enum `ps2_state_t` (IDLE, DATA, PARITY, STOP);
  - `PS2_DATA_BITS`=8;
  - `PS2_FRAME_BITS`=11.
- Sub-module `sync_fifo`, parameterized on width and depth, with ports push/pop/wdata/rdata/full/empty. The receiver FSM, synchronizers, and timeout counter live in `ps2_keyboard_rx`.

## Test plan
- Send frame 0x1C (parity 0) with `ready`=1 → one `valid` cycle with `data`=8'h1C, no error pulses.
- Send 0xF0, 0x1C with `ready`=0 → `valid` held, `data`=8'hF0. Raise `ready` for 2 cycles → 8'hF0 then 8'h1C, then `valid`=0.
- Send 0x1C with the parity bit flipped → one `parity_err` pulse, `valid` stays 0. Send a frame with stop=0 → one `frame_err` pulse, no push.
- Stop `ps2_clk` after 5 bits for TIMEOUT_CYCLES → `frame_err` pulse, state IDLE. A following good frame 0x32 → `data`=8'h32.
- With `ready`=0, send 9 frames at FIFO_DEPTH=8 → `overflow`=1 and the first 8 bytes are intact in order. Repeat with a pop in the 9th push cycle → all 9 bytes kept, `overflow`=0.
- Assert `rst` mid-frame with 3 bytes queued → `valid`=0 next cycle. A following frame 0x45 → `data`=8'h45.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and frame constants for the PS/2 keyboard receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    localparam int PS2_DATA_BITS  = 8;
    localparam int PS2_FRAME_BITS = 11;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; a push while full is accepted only alongside a pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             wr_en;
    logic             rd_en;

    // The extra pointer bit separates full from empty when the indices match.
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign wr_en = push & (~full | pop);
    assign rd_en = pop & ~empty;
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem[wr_ptr[AW-1:0]] <= wdata;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronizes the pins, decodes 11-bit frames and
// queues good scan-code bytes for a valid/ready consumer.
//
// state  | meaning
// IDLE   | waiting for a start bit; timeout counter parked
// DATA   | shifting in the 8 data bits, LSB first
// PARITY | capturing the odd parity bit
// STOP   | checking the stop bit, then push or report an error
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       ready,
    output logic       valid,
    output logic [7:0] data,
    output logic       overflow,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int CNT_W = $clog2(PS2_DATA_BITS);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES);

    logic clk_s0, clk_s1, clk_s2;
    logic dat_s0, dat_s1;
    logic fall;

    ps2_state_t         state_q, state_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [7:0]         shift_q, shift_d;
    logic               par_q, par_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               parity_err_d, frame_err_d;
    logic               push;
    logic               pop;
    logic               fifo_full, fifo_empty;

    // Synchronizers reset to the idle line level so reset never looks like an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s0 <= 1'b1;
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s0 <= 1'b1;
            dat_s1 <= 1'b1;
        end else begin
            clk_s0 <= ps2_clk;
            clk_s1 <= clk_s0;
            clk_s2 <= clk_s1;
            dat_s0 <= ps2_data;
            dat_s1 <= dat_s0;
        end
    end

    assign fall = clk_s2 & ~clk_s1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            tmo_q      <= TMO_LOAD;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            tmo_q      <= tmo_d;
            parity_err <= parity_err_d;
            frame_err  <= frame_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_d        = par_q;
        tmo_d        = tmo_q;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
        push         = 1'b0;

        case (state_q)
            IDLE: begin
                tmo_d = TMO_LOAD;
                if (fall) begin
                    if (!dat_s1) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                        shift_d   = '0;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            DATA: begin
                if (fall) begin
                    shift_d[bit_cnt_q] = dat_s1;
                    bit_cnt_d          = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(PS2_DATA_BITS - 1)) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (fall) begin
                    par_d   = dat_s1;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    state_d = IDLE;
                    // A bad stop bit outranks a parity failure.
                    if (!dat_s1) begin
                        frame_err_d = 1'b1;
                    end else if (~^{shift_q, par_q}) begin
                        parity_err_d = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Down-counter reloaded on every edge; expiring mid-frame abandons the frame.
        if (state_q != IDLE) begin
            if (fall) begin
                tmo_d = TMO_LOAD;
            end else if (tmo_q == '0) begin
                state_d     = IDLE;
                frame_err_d = 1'b1;
            end else begin
                tmo_d = tmo_q - TMO_W'(1);
            end
        end
    end

    assign valid = ~fifo_empty;
    assign pop   = valid & ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (push && fifo_full && !pop) begin
            overflow <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (PS2_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (shift_q),
        .rdata (data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Self-checking bench for ps2_keyboard_rx: vector table, corner-case sequences
// and randomized frames against a frame-level outcome model.
module tb_ps2_keyboard_rx;
    import ps2_pkg::*;

    localparam int FIFO_DEPTH = 8;
    localparam int TMO        = 300;
    localparam int H          = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic       ready;
    logic       valid;
    logic [7:0] data;
    logic       overflow;
    logic       parity_err;
    logic       frame_err;

    always #5 clk = ~clk;

    ps2_keyboard_rx #(
        .FIFO_DEPTH     (FIFO_DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .ready      (ready),
        .valid      (valid),
        .data       (data),
        .overflow   (overflow),
        .parity_err (parity_err),
        .frame_err  (frame_err)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int perr_cnt = 0;
    int ferr_cnt = 0;
    logic [7:0] pop_q[$];
    logic [7:0] exp_q[$];
    logic rand_mode = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (valid && ready) pop_q.push_back(data);
            if (parity_err) perr_cnt++;
            if (frame_err) ferr_cnt++;
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: bench did not finish, checks passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rand_mode) ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic clear_log();
        pop_q.delete();
        perr_cnt = 0;
        ferr_cnt = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] d, input logic flip, input logic stop_bad);
        logic par;
        par = ~(^d) ^ flip;
        return {~stop_bad, par, d, 1'b0};
    endfunction

    // 0 = byte delivered, 1 = parity error, 2 = framing error
    function automatic int outcome(input logic [10:0] f);
        if (f[0] || !f[PS2_FRAME_BITS-1]) return 2;
        if (($countones(f[9:1]) % 2) == 0) return 1;
        return 0;
    endfunction

    // Drives the first n bits of a frame; optionally pops in the stop-bit push cycle.
    task automatic send_bits(input logic [10:0] bits, input int n, input logic pop_at_last);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            tick(H);
            ps2_clk = 1'b0;
            if (pop_at_last && i == n - 1) begin
                tick(2);
                ready = 1'b1;
                tick(1);
                ready = 1'b0;
                tick(H - 3);
            end else begin
                tick(H);
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        tick(H);
    endtask

    task automatic send_byte(input logic [7:0] d);
        send_bits(make_frame(d, 1'b0, 1'b0), PS2_FRAME_BITS, 1'b0);
    endtask

    typedef struct {
        logic [7:0]  d;
        logic        flip;
        logic        stop_bad;
        logic        start_bad;
        int          exp_pops;
        logic [31:0] exp_data;
        int          exp_perr;
        int          exp_ferr;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [31:0] got;
        logic [10:0] f;
        int          oc, exp_perr, exp_ferr;

        vecs[0] = '{8'h1C, 1'b0, 1'b0, 1'b0, 1, 32'h1C, 0, 0};
        vecs[1] = '{8'h1C, 1'b1, 1'b0, 1'b0, 0, 32'hFFFF_FFFF, 1, 0};
        vecs[2] = '{8'h55, 1'b0, 1'b1, 1'b0, 0, 32'hFFFF_FFFF, 0, 1};
        vecs[3] = '{8'h1C, 1'b1, 1'b1, 1'b0, 0, 32'hFFFF_FFFF, 0, 1};
        vecs[4] = '{8'h00, 1'b0, 1'b0, 1'b0, 1, 32'h00, 0, 0};
        vecs[5] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1, 32'hFF, 0, 0};
        vecs[6] = '{8'h80, 1'b0, 1'b0, 1'b0, 1, 32'h80, 0, 0};
        vecs[7] = '{8'hA5, 1'b0, 1'b0, 1'b1, 0, 32'hFFFF_FFFF, 0, 1};

        rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; ready = 1'b0;
        tick(3);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_data", 32'(data), 32'h00);
        check("reset_overflow", 32'(overflow), 32'd0);
        check("reset_parity_err", 32'(parity_err), 32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        rst = 1'b0;
        tick(2);

        // Vector table, consumer always ready
        ready = 1'b1;
        for (int v = 0; v < 8; v++) begin
            clear_log();
            if (vecs[v].start_bad) send_bits(11'h7FF, 1, 1'b0);
            else send_bits(make_frame(vecs[v].d, vecs[v].flip, vecs[v].stop_bad), PS2_FRAME_BITS, 1'b0);
            tick(8);
            check($sformatf("vec%0d_pops", v), 32'(pop_q.size()), 32'(vecs[v].exp_pops));
            got = (pop_q.size() > 0) ? 32'(pop_q[0]) : 32'hFFFF_FFFF;
            check($sformatf("vec%0d_data", v), got, vecs[v].exp_data);
            check($sformatf("vec%0d_parity_err", v), 32'(perr_cnt), 32'(vecs[v].exp_perr));
            check($sformatf("vec%0d_frame_err", v), 32'(ferr_cnt), 32'(vecs[v].exp_ferr));
        end

        // Held head byte, then two-cycle drain
        ready = 1'b0;
        clear_log();
        send_byte(8'hF0);
        send_byte(8'h1C);
        tick(2);
        check("hold_valid", 32'(valid), 32'd1);
        check("hold_data", 32'(data), 32'hF0);
        ready = 1'b1;
        check("drain_first", 32'(data), 32'hF0);
        tick(1);
        check("drain_second", 32'(data), 32'h1C);
        tick(1);
        ready = 1'b0;
        check("drain_empty", 32'(valid), 32'd0);
        check("drain_pops", 32'(pop_q.size()), 32'd2);

        // Timeout after a partial frame, then recovery
        ready = 1'b1;
        clear_log();
        send_bits(make_frame(8'h3C, 1'b0, 1'b0), 5, 1'b0);
        tick(TMO - 30);
        check("timeout_not_early", 32'(ferr_cnt), 32'd0);
        tick(60);
        check("timeout_frame_err", 32'(ferr_cnt), 32'd1);
        check("timeout_no_push", 32'(pop_q.size()), 32'd0);
        send_byte(8'h32);
        tick(8);
        got = (pop_q.size() > 0) ? 32'(pop_q[0]) : 32'hFFFF_FFFF;
        check("after_timeout_data", got, 32'h32);

        // Overflow: nine frames into an eight-deep FIFO
        do_reset();
        ready = 1'b0;
        clear_log();
        for (int i = 0; i < 9; i++) send_byte(8'h10 + 8'(i));
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_head", 32'(data), 32'h10);
        ready = 1'b1;
        tick(12);
        ready = 1'b0;
        check("ovf_pop_count", 32'(pop_q.size()), 32'd8);
        for (int i = 0; i < pop_q.size(); i++) check($sformatf("ovf_byte%0d", i), 32'(pop_q[i]), 32'h10 + 32'(i));
        check("ovf_sticky", 32'(overflow), 32'd1);
        do_reset();
        check("ovf_cleared_by_rst", 32'(overflow), 32'd0);

        // Pop coinciding with the ninth push keeps every byte
        clear_log();
        for (int i = 0; i < 8; i++) send_byte(8'h20 + 8'(i));
        send_bits(make_frame(8'h28, 1'b0, 1'b0), PS2_FRAME_BITS, 1'b1);
        check("pushpop_no_ovf", 32'(overflow), 32'd0);
        ready = 1'b1;
        tick(12);
        ready = 1'b0;
        check("pushpop_count", 32'(pop_q.size()), 32'd9);
        for (int i = 0; i < pop_q.size(); i++) check($sformatf("pushpop_byte%0d", i), 32'(pop_q[i]), 32'h20 + 32'(i));

        // Reset mid-frame with bytes queued
        clear_log();
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        check("pre_rst_valid", 32'(valid), 32'd1);
        send_bits(make_frame(8'h77, 1'b0, 1'b0), 4, 1'b0);
        rst = 1'b1;
        tick(1);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_data", 32'(data), 32'h00);
        rst = 1'b0;
        tick(2);
        send_byte(8'h45);
        tick(2);
        check("post_rst_valid", 32'(valid), 32'd1);
        check("post_rst_data", 32'(data), 32'h45);
        ready = 1'b1;
        tick(3);
        ready = 1'b0;

        // Randomized frames and random consumer against the frame model
        clear_log();
        exp_q.delete();
        exp_perr = 0;
        exp_ferr = 0;
        rand_mode = 1'b1;
        for (int n = 0; n < 24; n++) begin
            f  = make_frame(8'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
            oc = outcome(f);
            if (oc == 0) exp_q.push_back(f[8:1]);
            else if (oc == 1) exp_perr++;
            else exp_ferr++;
            send_bits(f, PS2_FRAME_BITS, 1'b0);
        end
        rand_mode = 1'b0;
        ready = 1'b1;
        tick(20);
        ready = 1'b0;
        check("rand_pop_count", 32'(pop_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < pop_q.size(); i++)
            check($sformatf("rand_byte%0d", i), 32'(pop_q[i]), 32'(exp_q[i]));
        check("rand_parity_err", 32'(perr_cnt), 32'(exp_perr));
        check("rand_frame_err", 32'(ferr_cnt), 32'(exp_ferr));
        check("rand_no_ovf", 32'(overflow), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
